// File: rtl/match_controller_if.sv
// Scoreboard game-control bus: pulse inputs in, registered
// match status out to the display multiplexer.
interface match_controller_if;
  logic       tick;
  logic       start;
  logic       goal_a;
  logic       goal_b;
  logic [2:0] state;
  logic       en_score;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic [7:0] time_left;
  logic [1:0] winner;
  logic       finish;

  modport master (
    output tick, start, goal_a, goal_b,
    input  state, en_score, score_a, score_b,
    input  time_left, winner, finish
  );

  modport slave (
    input  tick, start, goal_a, goal_b,
    output state, en_score, score_a, score_b,
    output time_left, winner, finish
  );
endinterface

// File: rtl/match_controller.sv
// Match sequencer: idle, ready countdown, play, pause, finish,
// with BCD scores, BCD match timer and winner decision.
module match_controller #(
  parameter int GAME_SECONDS  = 60,
  parameter int READY_SECONDS = 3,
  parameter int WIN_SCORE     = 10
) (
  input logic          clk,
  input logic          rst,
  match_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    PLAY   = 3'd2,
    PAUSE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [7:0] GAME_BCD =
    {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  localparam logic [7:0] READY_BCD =
    {4'(READY_SECONDS / 10), 4'(READY_SECONDS % 10)};
  localparam logic [7:0] WIN_BCD =
    {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Saturates at 00 so the timer never underflows.
  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v
  );
    if (v == 8'h00)
      return 8'h00;
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  state_t     state_q;
  logic       en_q;
  logic [7:0] sa_q;
  logic [7:0] sb_q;
  logic [7:0] t_q;
  logic [1:0] win_q;
  logic       fin_q;

  logic [7:0] sa_n;
  logic [7:0] sb_n;
  logic [7:0] t_n;
  logic       end_hit;
  logic [1:0] win_n;

  always_comb begin
    sa_n = bus.goal_a ? bcd_inc(sa_q) : sa_q;
    sb_n = bus.goal_b ? bcd_inc(sb_q) : sb_q;
    t_n  = bus.tick ? bcd_dec(t_q) : t_q;
    end_hit = (sa_n == WIN_BCD) ||
              (sb_n == WIN_BCD) ||
              (t_n == 8'h00);
    if (sa_n > sb_n)
      win_n = 2'b01;
    else if (sb_n > sa_n)
      win_n = 2'b10;
    else
      win_n = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      sa_q    <= 8'h00;
      sb_q    <= 8'h00;
      t_q     <= GAME_BCD;
      win_q   <= 2'b00;
      fin_q   <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sa_q  <= 8'h00;
          sb_q  <= 8'h00;
          win_q <= 2'b00;
          en_q  <= 1'b0;
          t_q   <= GAME_BCD;
          if (bus.start) begin
            state_q <= READY;
            t_q     <= READY_BCD;
          end
        end
        READY: begin
          if (bus.tick) begin
            if (t_q == 8'h01) begin
              state_q <= PLAY;
              t_q     <= GAME_BCD;
              en_q    <= 1'b1;
            end else begin
              t_q <= bcd_dec(t_q);
            end
          end
        end
        PLAY: begin
          sa_q <= sa_n;
          sb_q <= sb_n;
          t_q  <= t_n;
          // End condition outranks a same-cycle pause request.
          if (end_hit) begin
            state_q <= FINISH;
            en_q    <= 1'b0;
            fin_q   <= 1'b1;
            win_q   <= win_n;
          end else if (bus.start) begin
            state_q <= PAUSE;
            en_q    <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.start) begin
            state_q <= PLAY;
            en_q    <= 1'b1;
          end
        end
        FINISH: begin
          if (bus.start) begin
            state_q <= IDLE;
            sa_q    <= 8'h00;
            sb_q    <= 8'h00;
            t_q     <= GAME_BCD;
            win_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          sa_q    <= 8'h00;
          sb_q    <= 8'h00;
          t_q     <= GAME_BCD;
          win_q   <= 2'b00;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.en_score  = en_q;
  assign bus.score_a   = sa_q;
  assign bus.score_b   = sb_q;
  assign bus.time_left = t_q;
  assign bus.winner    = win_q;
  assign bus.finish    = fin_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: integer match model checked every
// cycle, plus directed literal expectations on the main scenarios.
module tb_match_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic ga = 1'b0;
  logic gb = 1'b0;
  logic run = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_controller_if bus0 ();
  match_controller_if bus1 ();

  assign bus0.tick   = tick;
  assign bus0.start  = start;
  assign bus0.goal_a = ga;
  assign bus0.goal_b = gb;
  assign bus1.tick   = tick;
  assign bus1.start  = start;
  assign bus1.goal_a = ga;
  assign bus1.goal_b = gb;

  match_controller #(
    .GAME_SECONDS(5), .READY_SECONDS(3), .WIN_SCORE(3)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  match_controller #(
    .GAME_SECONDS(12), .READY_SECONDS(3), .WIN_SCORE(3)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic int game_of(input int i);
    return (i == 0) ? 5 : 12;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Match model: plain integers (seconds, goals) per instance.
  int m_st[2];
  int m_sa[2];
  int m_sb[2];
  int m_t[2];
  int m_w[2];
  int m_fin[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int st, sa, sb, t, w, fin;
      st = m_st[i]; sa = m_sa[i]; sb = m_sb[i];
      t = m_t[i]; w = m_w[i]; fin = 0;
      if (rst) begin
        st = 0; sa = 0; sb = 0; t = game_of(i); w = 0;
      end else if (st == 0) begin
        sa = 0; sb = 0; w = 0; t = game_of(i);
        if (start) begin st = 1; t = 3; end
      end else if (st == 1) begin
        if (tick) begin
          if (t > 1) t = t - 1;
          else begin st = 2; t = game_of(i); end
        end
      end else if (st == 2) begin
        sa = sa + (ga ? 1 : 0);
        sb = sb + (gb ? 1 : 0);
        if (tick && t > 0) t = t - 1;
        if (sa == 3 || sb == 3 || t == 0) begin
          st = 4; fin = 1;
          w = (sa > sb) ? 1 : (sb > sa) ? 2 : 3;
        end else if (start) st = 3;
      end else if (st == 3) begin
        if (start) st = 2;
      end else begin
        if (start) begin
          st = 0; sa = 0; sb = 0; t = game_of(i); w = 0;
        end
      end
      m_st[i] <= st; m_sa[i] <= sa; m_sb[i] <= sb;
      m_t[i] <= t; m_w[i] <= w; m_fin[i] <= fin;
    end
  end

  task automatic cmp(input int i,
                     input logic [2:0] st, input logic en,
                     input logic [7:0] sa, input logic [7:0] sb,
                     input logic [7:0] t, input logic [1:0] w,
                     input logic fin);
    chk($sformatf("m%0d.state", i), 8'(st), 8'(m_st[i]));
    chk($sformatf("m%0d.en", i), 8'(en), 8'(m_st[i] == 2));
    chk($sformatf("m%0d.sa", i), sa, bcd(m_sa[i]));
    chk($sformatf("m%0d.sb", i), sb, bcd(m_sb[i]));
    chk($sformatf("m%0d.time", i), t, bcd(m_t[i]));
    chk($sformatf("m%0d.win", i), 8'(w), 8'(m_w[i]));
    chk($sformatf("m%0d.fin", i), 8'(fin), 8'(m_fin[i]));
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp(0, bus0.state, bus0.en_score, bus0.score_a,
          bus0.score_b, bus0.time_left, bus0.winner,
          bus0.finish);
      cmp(1, bus1.state, bus1.en_score, bus1.score_a,
          bus1.score_b, bus1.time_left, bus1.winner,
          bus1.finish);
    end
  end

  task automatic cyc(input logic t, input logic s,
                     input logic a, input logic b);
    tick = t; start = s; ga = a; gb = b;
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; ga = 1'b0; gb = 1'b0;
  endtask

  task automatic to_play();
    cyc(0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #20 rst = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.state", 8'(bus0.state), 8'd0);
    chk("rst.time", bus0.time_left, 8'h05);
    chk("rst.time12", bus1.time_left, 8'h12);
    chk("rst.win", 8'(bus0.winner), 8'd0);
    chk("rst.fin", 8'(bus0.finish), 8'd0);

    cyc(0, 0, 1, 0);
    chk("idle.goal", bus0.score_a, 8'h00);
    cyc(0, 1, 0, 0);
    chk("ready.state", 8'(bus0.state), 8'd1);
    chk("ready.time", bus0.time_left, 8'h03);
    cyc(0, 0, 1, 0);
    chk("ready.goal", bus0.score_a, 8'h00);
    cyc(1, 0, 0, 0);
    chk("ready.t2", bus0.time_left, 8'h02);
    cyc(1, 0, 0, 0);
    chk("ready.t1", bus0.time_left, 8'h01);
    cyc(1, 0, 0, 0);
    chk("play.state", 8'(bus0.state), 8'd2);
    chk("play.time", bus0.time_left, 8'h05);
    chk("play.time12", bus1.time_left, 8'h12);

    cyc(0, 0, 1, 0);
    chk("play.goal", bus0.score_a, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst.state", 8'(bus0.state), 8'd0);
    chk("arst.sa", bus0.score_a, 8'h00);
    chk("arst.time", bus0.time_left, 8'h05);
    @(posedge clk);
    #1 rst = 1'b0;

    to_play();
    cyc(0, 0, 1, 1);
    chk("both.sa", bus0.score_a, 8'h01);
    chk("both.sb", bus0.score_b, 8'h01);
    chk("both.en", 8'(bus0.en_score), 8'd1);
    cyc(0, 1, 0, 0);
    chk("pause.state", 8'(bus0.state), 8'd3);
    cyc(1, 0, 1, 1);
    chk("pause.sa", bus0.score_a, 8'h01);
    chk("pause.time", bus0.time_left, 8'h05);
    cyc(0, 1, 0, 0);
    chk("resume.state", 8'(bus0.state), 8'd2);
    cyc(0, 0, 1, 0);
    chk("win.sa2", bus0.score_a, 8'h02);
    cyc(0, 0, 1, 0);
    chk("win.sa3", bus0.score_a, 8'h03);
    chk("win.state", 8'(bus0.state), 8'd4);
    chk("win.fin", 8'(bus0.finish), 8'd1);
    chk("win.winner", 8'(bus0.winner), 8'd1);
    cyc(0, 0, 0, 0);
    chk("win.fin0", 8'(bus0.finish), 8'd0);
    cyc(0, 1, 0, 0);
    chk("restart.state", 8'(bus0.state), 8'd0);
    chk("restart.sa", bus0.score_a, 8'h00);
    chk("restart.time", bus0.time_left, 8'h05);

    to_play();
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 0);
    chk("tmo.t4", bus0.time_left, 8'h04);
    cyc(1, 0, 0, 0);
    chk("tmo.t3", bus0.time_left, 8'h03);
    cyc(1, 0, 0, 0);
    chk("tmo.t2", bus0.time_left, 8'h02);
    cyc(1, 0, 0, 0);
    chk("tmo.t1", bus0.time_left, 8'h01);
    cyc(1, 1, 0, 0);
    chk("tmo.t0", bus0.time_left, 8'h00);
    chk("tmo.state", 8'(bus0.state), 8'd4);
    chk("tmo.winner", 8'(bus0.winner), 8'd3);
    chk("tmo.fin", 8'(bus0.finish), 8'd1);
    cyc(0, 1, 0, 0);
    chk("tmo.idle", 8'(bus0.state), 8'd0);

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    to_play();
    cyc(1, 0, 0, 0);
    chk("bcd.t11", bus1.time_left, 8'h11);
    cyc(1, 0, 0, 0);
    chk("bcd.t10", bus1.time_left, 8'h10);
    cyc(1, 0, 0, 0);
    chk("bcd.t09", bus1.time_left, 8'h09);
    repeat (2) cyc(0, 0, 0, 0);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
